// File: rtl/branch_predict_unit_if.sv
// Port bundle between the fetch/execute pipeline and the branch prediction unit.
// The pipeline is the master; the predictor is the slave.
interface branch_predict_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  update_predictor;
    logic                  update_btb;
    logic                  actually_taken;
    logic [DATA_WIDTH-1:0] resolved_pc;
    logic [DATA_WIDTH-1:0] resolved_pc_target;
    logic [DATA_WIDTH-1:0] pc;
    logic                  is_call;
    logic                  is_return;
    logic                  hit;
    logic                  pred;
    logic [DATA_WIDTH-1:0] branch_target;
    logic                  ras_valid;

    modport master (
        output update_predictor, update_btb, actually_taken,
        output resolved_pc, resolved_pc_target, pc, is_call, is_return,
        input  hit, pred, branch_target, ras_valid
    );

    modport slave (
        input  update_predictor, update_btb, actually_taken,
        input  resolved_pc, resolved_pc_target, pc, is_call, is_return,
        output hit, pred, branch_target, ras_valid
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Fetch-stage branch prediction: gshare direction predictor, tagged direct-mapped BTB and
// a circular return address stack. Lookups are combinational; all training happens on the edge.
module branch_predict_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 2,
    parameter int HIST_WIDTH    = 8,
    parameter int BTB_IDX_WIDTH = 6,
    parameter int RAS_DEPTH     = 8
) (
    input logic                  clk,
    input logic                  rstn,
    branch_predict_unit_if.slave bp
);
    localparam int PHT_ENTRIES = 1 << HIST_WIDTH;
    localparam int BTB_ENTRIES = 1 << BTB_IDX_WIDTH;
    localparam int TAG_WIDTH   = DATA_WIDTH - BTB_IDX_WIDTH - 2;
    localparam int PTR_WIDTH   = $clog2(RAS_DEPTH);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_MIN  = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]    PC_STEP  = {{(DATA_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [PTR_WIDTH-1:0]     PTR_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0]       CNT1_RAS = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0]       RAS_FULL = (PTR_WIDTH+1)'(RAS_DEPTH);

    logic [HIST_WIDTH-1:0]    ghr_r;
    logic [COUNTER_WIDTH-1:0] pht_r        [PHT_ENTRIES];
    logic                     btb_valid_r  [BTB_ENTRIES];
    logic [TAG_WIDTH-1:0]     btb_tag_r    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]    btb_target_r [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]    ras_stack_r  [RAS_DEPTH];
    logic [PTR_WIDTH-1:0]     ras_ptr_r;
    logic [PTR_WIDTH:0]       ras_count_r;

    logic [HIST_WIDTH-1:0]    pht_rd_idx_s;
    logic [COUNTER_WIDTH-1:0] pht_rd_cnt_s;
    logic                     pht_pred_s;
    logic [HIST_WIDTH-1:0]    pht_wr_idx_s;
    logic [COUNTER_WIDTH-1:0] pht_wr_old_s;
    logic [COUNTER_WIDTH-1:0] pht_wr_new_s;
    logic [BTB_IDX_WIDTH-1:0] btb_rd_idx_s;
    logic [TAG_WIDTH-1:0]     btb_rd_tag_s;
    logic                     btb_hit_s;
    logic [BTB_IDX_WIDTH-1:0] btb_wr_idx_s;
    logic [TAG_WIDTH-1:0]     btb_wr_tag_s;
    logic                     ras_nonempty_s;
    logic [PTR_WIDTH-1:0]     ras_top_idx_s;
    logic [DATA_WIDTH-1:0]    ras_link_s;
    logic                     ras_push_s;
    logic                     ras_replace_s;
    logic                     ras_pop_s;
    logic [1:0]               unused_rpc_s;

    assign unused_rpc_s = bp.resolved_pc[1:0];

    // Lookup and write-port index/tag extraction shared by all stateful blocks.
    always_comb begin
        pht_rd_idx_s   = bp.pc[HIST_WIDTH+1:2] ^ ghr_r;
        pht_rd_cnt_s   = pht_r[pht_rd_idx_s];
        pht_pred_s     = pht_rd_cnt_s[COUNTER_WIDTH-1];
        pht_wr_idx_s   = bp.resolved_pc[HIST_WIDTH+1:2] ^ ghr_r;
        pht_wr_old_s   = pht_r[pht_wr_idx_s];
        btb_rd_idx_s   = bp.pc[BTB_IDX_WIDTH+1:2];
        btb_rd_tag_s   = bp.pc[DATA_WIDTH-1:BTB_IDX_WIDTH+2];
        btb_hit_s      = btb_valid_r[btb_rd_idx_s] && (btb_tag_r[btb_rd_idx_s] == btb_rd_tag_s);
        btb_wr_idx_s   = bp.resolved_pc[BTB_IDX_WIDTH+1:2];
        btb_wr_tag_s   = bp.resolved_pc[DATA_WIDTH-1:BTB_IDX_WIDTH+2];
        ras_nonempty_s = (ras_count_r != {(PTR_WIDTH+1){1'b0}});
        ras_top_idx_s  = ras_ptr_r - PTR_ONE;
        ras_link_s     = bp.pc + PC_STEP;
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        pht_wr_new_s = pht_wr_old_s;
        if (bp.actually_taken) begin
            if (pht_wr_old_s != CNT_MAX) begin
                pht_wr_new_s = pht_wr_old_s + CNT_ONE;
            end else begin
                pht_wr_new_s = pht_wr_old_s;
            end
        end else begin
            if (pht_wr_old_s != CNT_MIN) begin
                pht_wr_new_s = pht_wr_old_s - CNT_ONE;
            end else begin
                pht_wr_new_s = pht_wr_old_s;
            end
        end
    end

    // RAS operation decode; a call+return on a non-empty stack rewrites the top in place.
    always_comb begin
        ras_replace_s = 1'b0;
        ras_push_s    = 1'b0;
        ras_pop_s     = 1'b0;
        if (bp.is_call && bp.is_return && ras_nonempty_s) begin
            ras_replace_s = 1'b1;
        end else if (bp.is_call) begin
            ras_push_s = 1'b1;
        end else if (bp.is_return && ras_nonempty_s) begin
            ras_pop_s = 1'b1;
        end else begin
            ras_push_s = 1'b0;
        end
    end

    // Output priority: pending return, then BTB hit, then direction only.
    always_comb begin
        bp.hit           = 1'b0;
        bp.pred          = pht_pred_s;
        bp.branch_target = {DATA_WIDTH{1'b0}};
        bp.ras_valid     = ras_nonempty_s;
        if (bp.is_return && ras_nonempty_s) begin
            bp.hit           = 1'b1;
            bp.pred          = 1'b1;
            bp.branch_target = ras_stack_r[ras_top_idx_s];
        end else if (btb_hit_s) begin
            bp.hit           = 1'b1;
            bp.branch_target = btb_target_r[btb_rd_idx_s];
        end else begin
            bp.hit           = 1'b0;
            bp.branch_target = {DATA_WIDTH{1'b0}};
        end
    end

    // Global history and pattern table training; the index uses the pre-shift history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ghr_r <= {HIST_WIDTH{1'b0}};
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_r[i] <= CNT_INIT;
            end
        end else if (bp.update_predictor) begin
            ghr_r               <= {ghr_r[HIST_WIDTH-2:0], bp.actually_taken};
            pht_r[pht_wr_idx_s] <= pht_wr_new_s;
        end
    end

    // BTB fill; a tag conflict simply replaces the resident entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_r[i]  <= 1'b0;
                btb_tag_r[i]    <= {TAG_WIDTH{1'b0}};
                btb_target_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (bp.update_btb) begin
            btb_valid_r[btb_wr_idx_s]  <= 1'b1;
            btb_tag_r[btb_wr_idx_s]    <= btb_wr_tag_s;
            btb_target_r[btb_wr_idx_s] <= bp.resolved_pc_target;
        end
    end

    // Circular return stack; on overflow the pointer wraps over the oldest entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ras_ptr_r   <= {PTR_WIDTH{1'b0}};
            ras_count_r <= {(PTR_WIDTH+1){1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_stack_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (ras_replace_s) begin
            ras_stack_r[ras_top_idx_s] <= ras_link_s;
        end else if (ras_push_s) begin
            ras_stack_r[ras_ptr_r] <= ras_link_s;
            ras_ptr_r              <= ras_ptr_r + PTR_ONE;
            if (ras_count_r != RAS_FULL) begin
                ras_count_r <= ras_count_r + CNT1_RAS;
            end
        end else if (ras_pop_s) begin
            ras_ptr_r   <= ras_top_idx_s;
            ras_count_r <= ras_count_r - CNT1_RAS;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised bench for branch_predict_unit against a queue/array reference model,
// with directed literal expectations for the documented corner cases.
module tb_branch_predict_unit;
    localparam int DW     = 32;
    localparam int CW     = 2;
    localparam int HW     = 8;
    localparam int BI     = 6;
    localparam int RD     = 8;
    localparam int PHT_N  = 1 << HW;
    localparam int BTB_N  = 1 << BI;
    localparam int C_MAX  = (1 << CW) - 1;
    localparam int C_INIT = (1 << (CW - 1)) - 1;
    localparam int C_THR  = 1 << (CW - 1);

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.DATA_WIDTH(DW)) bus ();

    branch_predict_unit #(
        .DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .HIST_WIDTH(HW),
        .BTB_IDX_WIDTH(BI), .RAS_DEPTH(RD)
    ) dut (
        .clk(clk), .rstn(rstn), .bp(bus)
    );

    // reference state
    int unsigned m_ghr;
    int unsigned m_pht [PHT_N];
    bit          m_bv  [BTB_N];
    logic [31:0] m_btag[BTB_N];
    logic [31:0] m_btgt[BTB_N];
    logic [31:0] m_ras [$];

    int n_checks = 0;
    int n_pass   = 0;

    logic        lit_en = 1'b0;
    logic        lit_hit, lit_pred, lit_rv;
    logic [31:0] lit_tgt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // reference update: bounded queue stands in for the circular stack
    always @(posedge clk or negedge rstn) begin
        int unsigned u;
        int unsigned b;
        if (!rstn) begin
            m_ghr = 0;
            for (int i = 0; i < PHT_N; i++) m_pht[i] = C_INIT;
            for (int i = 0; i < BTB_N; i++) begin
                m_bv[i] = 1'b0; m_btag[i] = 32'h0; m_btgt[i] = 32'h0;
            end
            m_ras.delete();
        end else begin
            if (bus.update_predictor) begin
                u = ((bus.resolved_pc >> 2) % PHT_N) ^ m_ghr;
                if (bus.actually_taken && m_pht[u] < C_MAX) m_pht[u] = m_pht[u] + 1;
                else if (!bus.actually_taken && m_pht[u] > 0) m_pht[u] = m_pht[u] - 1;
                m_ghr = ((m_ghr << 1) | {31'b0, bus.actually_taken}) % PHT_N;
            end
            if (bus.update_btb) begin
                b = (bus.resolved_pc >> 2) % BTB_N;
                m_bv[b]   = 1'b1;
                m_btag[b] = bus.resolved_pc >> (BI + 2);
                m_btgt[b] = bus.resolved_pc_target;
            end
            if (bus.is_call && bus.is_return && m_ras.size() > 0) begin
                m_ras[m_ras.size()-1] = bus.pc + 32'd4;
            end else if (bus.is_call) begin
                m_ras.push_back(bus.pc + 32'd4);
                if (m_ras.size() > RD) m_ras.delete(0);
            end else if (bus.is_return && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
    end

    // compare process: every negedge, outputs against the reference and optional literals
    always @(negedge clk) begin
        logic        e_hit, e_pred, e_rv;
        logic [31:0] e_tgt;
        int unsigned pidx, bidx;
        e_rv  = (m_ras.size() > 0);
        pidx  = ((bus.pc >> 2) % PHT_N) ^ m_ghr;
        bidx  = (bus.pc >> 2) % BTB_N;
        e_pred = (m_pht[pidx] >= C_THR);
        if (bus.is_return && m_ras.size() > 0) begin
            e_hit = 1'b1; e_pred = 1'b1; e_tgt = m_ras[$];
        end else if (m_bv[bidx] && m_btag[bidx] == (bus.pc >> (BI + 2))) begin
            e_hit = 1'b1; e_tgt = m_btgt[bidx];
        end else begin
            e_hit = 1'b0; e_tgt = 32'h0;
        end
        chk("hit",       {31'b0, bus.hit},       {31'b0, e_hit});
        chk("pred",      {31'b0, bus.pred},      {31'b0, e_pred});
        chk("target",    bus.branch_target,      e_tgt);
        chk("ras_valid", {31'b0, bus.ras_valid}, {31'b0, e_rv});
        if (lit_en) begin
            chk("lit_hit",       {31'b0, bus.hit},       {31'b0, lit_hit});
            chk("lit_pred",      {31'b0, bus.pred},      {31'b0, lit_pred});
            chk("lit_target",    bus.branch_target,      lit_tgt);
            chk("lit_ras_valid", {31'b0, bus.ras_valid}, {31'b0, lit_rv});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
        bus.update_predictor = 1'b0;
        bus.update_btb       = 1'b0;
        bus.is_call          = 1'b0;
        bus.is_return        = 1'b0;
    endtask

    task automatic lit(input logic h, input logic p, input logic [31:0] t, input logic rv);
        lit_en = 1'b1; lit_hit = h; lit_pred = p; lit_tgt = t; lit_rv = rv;
    endtask

    task automatic train(input logic [31:0] rpc, input logic tk);
        tick();
        bus.update_predictor = 1'b1; bus.resolved_pc = rpc; bus.actually_taken = tk;
    endtask

    initial begin
        rstn = 1'b0;
        bus.update_predictor = 1'b0; bus.update_btb = 1'b0; bus.actually_taken = 1'b0;
        bus.resolved_pc = 32'h0; bus.resolved_pc_target = 32'h0;
        bus.pc = 32'h100; bus.is_call = 1'b0; bus.is_return = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // reset state
        tick(); bus.pc = 32'h100; lit(1'b0, 1'b0, 32'h0, 1'b0);

        // BTB fill; same-cycle read still sees the empty entry
        tick(); bus.update_btb = 1'b1; bus.resolved_pc = 32'h100; bus.resolved_pc_target = 32'h200;
        lit(1'b0, 1'b0, 32'h0, 1'b0);
        tick(); bus.pc = 32'h100; lit(1'b1, 1'b0, 32'h200, 1'b0);
        tick(); bus.pc = 32'h200; lit(1'b0, 1'b0, 32'h0, 1'b0);

        // drive one counter (index 0x10) up to saturation while GHR walks 0,1,3 -> 7
        train(32'h40, 1'b1); bus.pc = 32'h40; lit(1'b0, 1'b0, 32'h0, 1'b0);
        train(32'h44, 1'b1);
        train(32'h4C, 1'b1);
        tick(); bus.pc = 32'h5C; lit(1'b0, 1'b1, 32'h0, 1'b0);
        // four not-taken on the same counter: 11,10,01,00,00
        train(32'h5C, 1'b0);
        train(32'h78, 1'b0);
        train(32'h30, 1'b0);
        train(32'hA0, 1'b0);
        tick(); bus.pc = 32'h180; lit(1'b0, 1'b0, 32'h0, 1'b0);

        // RAS overflow: nine calls, then returns newest first
        for (int k = 0; k < 9; k++) begin
            tick(); bus.pc = 32'h1000 + 32'(16 * k); bus.is_call = 1'b1;
        end
        for (int j = 0; j < 8; j++) begin
            tick(); bus.pc = 32'h2000; bus.is_return = 1'b1;
            lit(1'b1, 1'b1, 32'h1084 - 32'(16 * j), 1'b1);
        end
        tick(); bus.pc = 32'h100; bus.is_return = 1'b1; lit(1'b1, 1'b0, 32'h200, 1'b0);

        // simultaneous call+return replaces the top
        tick(); bus.pc = 32'h600; bus.is_call = 1'b1;
        tick(); bus.pc = 32'h610; bus.is_call = 1'b1;
        tick(); bus.pc = 32'h500; bus.is_call = 1'b1; bus.is_return = 1'b1;
        lit(1'b1, 1'b1, 32'h614, 1'b1);
        tick(); bus.pc = 32'h2000; bus.is_return = 1'b1; lit(1'b1, 1'b1, 32'h504, 1'b1);
        tick(); bus.pc = 32'h2000; bus.is_return = 1'b1; lit(1'b1, 1'b1, 32'h604, 1'b1);
        tick(); bus.pc = 32'h2000; lit(1'b0, 1'b0, 32'h0, 1'b0);
        // on an empty stack it behaves as a push
        tick(); bus.pc = 32'h500; bus.is_call = 1'b1; bus.is_return = 1'b1;
        lit(1'b0, 1'b0, 32'h0, 1'b0);
        tick(); bus.pc = 32'h2000; bus.is_return = 1'b1; lit(1'b1, 1'b1, 32'h504, 1'b1);
        tick(); bus.pc = 32'h2000; lit(1'b0, 1'b0, 32'h0, 1'b0);

        // randomised traffic with aliasing tags
        for (int n = 0; n < 1500; n++) begin
            tick();
            bus.pc                 = (($urandom % 32'd4) << 12) | (($urandom % 32'd1024) << 2);
            bus.resolved_pc        = (($urandom % 32'd4) << 12) | (($urandom % 32'd1024) << 2);
            bus.resolved_pc_target = $urandom;
            bus.actually_taken     = 1'($urandom % 32'd2);
            bus.update_predictor   = ($urandom % 32'd3) == 32'd0;
            bus.update_btb         = ($urandom % 32'd3) == 32'd0;
            bus.is_call            = ($urandom % 32'd6) == 32'd0;
            bus.is_return          = ($urandom % 32'd6) == 32'd0;
        end

        // load state, then drop reset between clock edges
        tick(); bus.update_btb = 1'b1; bus.resolved_pc = 32'h100; bus.resolved_pc_target = 32'h300;
        tick(); bus.pc = 32'h900; bus.is_call = 1'b1;
        tick(); bus.pc = 32'h910; bus.is_call = 1'b1;
        @(posedge clk);
        #3;
        lit_en = 1'b0; bus.is_call = 1'b0;
        rstn = 1'b0; bus.pc = 32'h100; bus.is_return = 1'b1;
        lit(1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1 lit_en = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        bus.is_return = 1'b0; bus.pc = 32'h100; lit(1'b0, 1'b0, 32'h0, 1'b0);
        tick(); bus.pc = 32'h40; lit(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
